// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the program counter generator.
//   pc_cmd_e : 3-bit operation code driven on pc_gen.pc_cmd
//              (codes 6 and 7 are reserved and behave as CMD_INC)
//   PC_STEP  : sequential instruction stride in bytes
package pc_pkg;

    localparam int unsigned PC_STEP = 4;

    typedef enum logic [2:0] {
        CMD_INC      = 3'd0,
        CMD_REL      = 3'd1,
        CMD_ABS      = 3'd2,
        CMD_CALL_ABS = 3'd3,
        CMD_CALL_REL = 3'd4,
        CMD_RET      = 3'd5
    } pc_cmd_e;

endpackage

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack.
//   clk        : rising-edge clock
//   reset_n    : synchronous active-low reset (clears count and pointer only)
//   push       : write push_data as the new top entry
//   pop        : discard the top entry (ignored when empty)
//   push_data  : return address to store
//   top        : newest entry (meaningless while empty)
//   empty/full : occupancy decoded from the registered count
//   overflow   : push while full (oldest entry is overwritten)
//   underflow  : pop while empty (stack stays empty)
module ras_stack #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         full,
    output logic         overflow,
    output logic         underflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [CW-1:0] count;
    logic [PW-1:0] ptr;       // next slot to write; ptr-1 is the top
    logic [PW-1:0] ptr_inc;
    logic [PW-1:0] ptr_dec;

    assign ptr_inc = (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    assign ptr_dec = (ptr == '0) ? PW'(DEPTH - 1) : ptr - 1'b1;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign overflow  = push & full;
    assign underflow = pop & ~push & empty;
    assign top       = mem[ptr_dec];

    // When full, ptr already points at the oldest entry, so a push
    // overwrites it and the count saturates.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
            ptr   <= '0;
        end else if (push) begin
            ptr <= ptr_inc;
            if (!full) count <= count + 1'b1;
        end else if (pop && !empty) begin
            ptr   <= ptr_dec;
            count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[ptr] <= push_data;
    end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: program counter generator with optional return-address stack.
// Build option: define PC_GEN_RAS_EN to include the RAS; otherwise the
// call codes act as plain jumps, RET acts as INC, and the RAS flags are tied.
//   clk         : rising-edge clock
//   reset_n     : synchronous active-low reset (highest priority)
//   pc_en       : advance enable; PC and RAS hold when low
//   pc_cmd      : operation code (pc_pkg::pc_cmd_e)
//   pc_v        : offset (REL, CALL_REL) or target (ABS, CALL_ABS)
//   flush       : redirect to flush_addr, overrides pc_en/pc_cmd
//   flush_addr  : redirect target
//   i_address   : current PC
//   ras_empty   : RAS holds no entries
//   ras_full    : RAS holds RAS_DEPTH entries
//   ras_err     : one-cycle pulse after a RAS overflow or underflow
module pc_gen
    import pc_pkg::*;
#(
    parameter int            AW        = 32,
    parameter logic [AW-1:0] RESET_VEC = '0,
    parameter int            RAS_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          pc_en,
    input  logic [2:0]    pc_cmd,
    input  logic [AW-1:0] pc_v,
    input  logic          flush,
    input  logic [AW-1:0] flush_addr,
    output logic [AW-1:0] i_address,
    output logic          ras_empty,
    output logic          ras_full,
    output logic          ras_err
);

    if (AW < 8 || AW > 64) begin : g_aw_check
        $error("pc_gen: AW out of range 8..64");
    end
    if (RAS_DEPTH < 2 || RAS_DEPTH > 16) begin : g_depth_check
        $error("pc_gen: RAS_DEPTH out of range 2..16");
    end
    if (RESET_VEC[1:0] != 2'b00) begin : g_vec_check
        $error("pc_gen: RESET_VEC must be 4-byte aligned");
    end

    pc_cmd_e       cmd;
    logic [AW-1:0] pc;
    logic [AW-1:0] pc_inc;
    logic [AW-1:0] pc_rel;
    logic [AW-1:0] pc_next;

    assign cmd       = pc_cmd_e'(pc_cmd);
    assign pc_inc    = pc + AW'(PC_STEP);
    assign pc_rel    = pc + pc_v;
    assign i_address = pc;

`ifdef PC_GEN_RAS_EN
    logic          step;
    logic          push;
    logic          pop;
    logic          overflow;
    logic          underflow;
    logic [AW-1:0] ras_top;
    logic          ras_err_q;

    assign step = ~flush & pc_en;
    assign push = step & ((cmd == CMD_CALL_ABS) | (cmd == CMD_CALL_REL));
    assign pop  = step & (cmd == CMD_RET);

    ras_stack #(
        .W     (AW),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) ras_err_q <= 1'b0;
        else          ras_err_q <= overflow | underflow;
    end
    assign ras_err = ras_err_q;
`else
    assign ras_empty = 1'b1;
    assign ras_full  = 1'b0;
    assign ras_err   = 1'b0;
`endif

    always_comb begin
        pc_next = pc;
        if (flush) begin
            pc_next = flush_addr;
        end else if (pc_en) begin
            case (cmd)
                CMD_REL,
                CMD_CALL_REL: pc_next = pc_rel;
                CMD_ABS,
                CMD_CALL_ABS: pc_next = pc_v;
`ifdef PC_GEN_RAS_EN
                CMD_RET:      pc_next = ras_empty ? pc_inc : ras_top;
`endif
                default:      pc_next = pc_inc;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) pc <= RESET_VEC;
        else          pc <= pc_next;
    end

endmodule
